// File: rtl/mem_read_arbiter.sv
// Shares one read port between fetch (I) and MEM (D), one read outstanding; grant in the request cycle, S_AR one cycle later.
// Losers and late requesters see ARREADY=0 and hold; R backpressure is the owner's RREADY passed straight through.
module mem_read_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] I_ARADDR,
   input  logic              I_ARVALID,
   output logic              I_ARREADY,
   output logic [DATA_W-1:0] I_RDATA,
   output logic              I_RVALID,
   input  logic              I_RREADY,
   input  logic [ADDR_W-1:0] D_ARADDR,
   input  logic              D_ARVALID,
   output logic              D_ARREADY,
   output logic [DATA_W-1:0] D_RDATA,
   output logic              D_RVALID,
   input  logic              D_RREADY,
   output logic [ADDR_W-1:0] S_ARADDR,
   output logic              S_ARVALID,
   input  logic              S_ARREADY,
   input  logic [DATA_W-1:0] S_RDATA,
   input  logic              S_RVALID,
   output logic              S_RREADY,
   output logic              OWNER
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] araddr_q, araddr_d;
   logic              arvalid_q, arvalid_d;
   logic              owner_q, owner_d;
   logic [SW-1:0]     streak_q, streak_d;
   logic              d_wins;

   // I only overtakes D once D has won LIMIT times in a row while I was waiting.
   assign d_wins = D_ARVALID && !(I_ARVALID && (streak_q == LIMIT));

   always_comb begin
      state_d   = state_q;
      araddr_d  = araddr_q;
      arvalid_d = arvalid_q;
      owner_d   = owner_q;
      streak_d  = streak_q;
      I_ARREADY = 1'b0;
      D_ARREADY = 1'b0;
      I_RVALID  = 1'b0;
      D_RVALID  = 1'b0;
      S_RREADY  = 1'b0;
      case (state_q)
         IDLE: begin
            if (d_wins) begin
               D_ARREADY = 1'b1;
               araddr_d  = D_ARADDR;
               owner_d   = 1'b1;
               arvalid_d = 1'b1;
               state_d   = ADDR;
               if (I_ARVALID)
                  streak_d = streak_q + SW'(1);
            end else if (I_ARVALID) begin
               I_ARREADY = 1'b1;
               araddr_d  = I_ARADDR;
               owner_d   = 1'b0;
               arvalid_d = 1'b1;
               state_d   = ADDR;
               streak_d  = '0;
            end
         end
         ADDR: begin
            if (S_ARREADY) begin
               arvalid_d = 1'b0;
               state_d   = DATA;
            end
         end
         DATA: begin
            S_RREADY = owner_q ? D_RREADY : I_RREADY;
            I_RVALID = !owner_q && S_RVALID;
            D_RVALID = owner_q && S_RVALID;
            if (S_RVALID && S_RREADY)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         araddr_q  <= '0;
         arvalid_q <= 1'b0;
         owner_q   <= 1'b0;
         streak_q  <= '0;
      end else begin
         state_q   <= state_d;
         araddr_q  <= araddr_d;
         arvalid_q <= arvalid_d;
         owner_q   <= owner_d;
         streak_q  <= streak_d;
      end
   end

   assign S_ARADDR  = araddr_q;
   assign S_ARVALID = arvalid_q;
   assign OWNER     = owner_q;
   assign I_RDATA   = S_RDATA;
   assign D_RDATA   = S_RDATA;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter: a transaction-level reference checked every cycle plus literal spot checks.
module tb_mem_read_arbiter;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int LIM = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] I_ARADDR, D_ARADDR, S_ARADDR;
   logic          I_ARVALID, I_ARREADY, I_RVALID, I_RREADY;
   logic          D_ARVALID, D_ARREADY, D_RVALID, D_RREADY;
   logic [DW-1:0] I_RDATA, D_RDATA, S_RDATA;
   logic          S_ARVALID, S_ARREADY, S_RVALID, S_RREADY, OWNER;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
      .clk(clk), .rst_n(rst_n),
      .I_ARADDR(I_ARADDR), .I_ARVALID(I_ARVALID), .I_ARREADY(I_ARREADY),
      .I_RDATA(I_RDATA), .I_RVALID(I_RVALID), .I_RREADY(I_RREADY),
      .D_ARADDR(D_ARADDR), .D_ARVALID(D_ARVALID), .D_ARREADY(D_ARREADY),
      .D_RDATA(D_RDATA), .D_RVALID(D_RVALID), .D_RREADY(D_RREADY),
      .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
      .S_RDATA(S_RDATA), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
      .OWNER(OWNER)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: 'busy' says a read is in flight, 'sent' says its address was taken by the slave.
   bit          live = 0;
   bit          busy, sent, m_own;
   int          m_streak;
   logic [AW-1:0] m_addr;

   always @(posedge clk) begin
      if (!rst_n) begin
         live = 1; busy = 0; sent = 0; m_own = 0; m_streak = 0; m_addr = '0;
      end else if (live) begin
         if (!busy) begin
            if (D_ARVALID && !(I_ARVALID && m_streak == LIM)) begin
               busy = 1; m_own = 1; m_addr = D_ARADDR;
               if (I_ARVALID && m_streak < LIM) m_streak++;
            end else if (I_ARVALID) begin
               busy = 1; m_own = 0; m_addr = I_ARADDR; m_streak = 0;
            end
         end else if (!sent) begin
            if (S_ARREADY) sent = 1;
         end else if (S_RVALID && (m_own ? D_RREADY : I_RREADY)) begin
            busy = 0; sent = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (live) begin
         logic e_d, e_i, in_data;
         e_d = !busy && D_ARVALID && !(I_ARVALID && m_streak == LIM);
         e_i = !busy && I_ARVALID && !e_d;
         in_data = busy && sent;
         chk("D_ARREADY", D_ARREADY, e_d);
         chk("I_ARREADY", I_ARREADY, e_i);
         chk("S_ARVALID", S_ARVALID, busy && !sent);
         chk("S_ARADDR", S_ARADDR, m_addr);
         chk("OWNER", OWNER, m_own);
         chk("S_RREADY", S_RREADY, in_data && (m_own ? D_RREADY : I_RREADY));
         chk("I_RVALID", I_RVALID, in_data && !m_own && S_RVALID);
         chk("D_RVALID", D_RVALID, in_data && m_own && S_RVALID);
         chk("I_RDATA", I_RDATA, S_RDATA);
         chk("D_RDATA", D_RDATA, S_RDATA);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Completes an issued read: address accepted, then one R beat accepted by both requesters.
   task automatic serve(input logic [DW-1:0] data);
      S_ARREADY = 1'b1;
      step();
      S_ARREADY = 1'b0;
      S_RVALID = 1'b1; S_RDATA = data; I_RREADY = 1'b1; D_RREADY = 1'b1;
      step();
      S_RVALID = 1'b0; I_RREADY = 1'b0; D_RREADY = 1'b0;
   endtask

   logic [5:0] grants;

   initial begin
      rst_n = 1'b0;
      I_ARADDR = '0; I_ARVALID = 0; I_RREADY = 0;
      D_ARADDR = '0; D_ARVALID = 0; D_RREADY = 0;
      S_ARREADY = 0; S_RDATA = '0; S_RVALID = 0;
      step(); step();
      rst_n = 1'b1;
      #1;
      chk("reset S_ARVALID", S_ARVALID, 0);
      chk("reset S_ARADDR", S_ARADDR, 0);
      chk("reset OWNER", OWNER, 0);

      // 1: lone fetch
      I_ARVALID = 1; I_ARADDR = 32'h40;
      #1 chk("t1 I_ARREADY", I_ARREADY, 1);
      step();
      I_ARVALID = 0;
      #1 chk("t1 S_ARVALID", S_ARVALID, 1);
      chk("t1 S_ARADDR", S_ARADDR, 32'h40);
      S_ARREADY = 1;
      step();
      S_ARREADY = 0; S_RVALID = 1; S_RDATA = 32'hDEAD_BEEF; I_RREADY = 1;
      #1 chk("t1 I_RVALID", I_RVALID, 1);
      chk("t1 I_RDATA", I_RDATA, 32'hDEAD_BEEF);
      chk("t1 D_RVALID", D_RVALID, 0);
      chk("t1 OWNER", OWNER, 0);
      step();
      S_RVALID = 0; I_RREADY = 0;

      // 2: simultaneous requests, D first
      D_ARVALID = 1; D_ARADDR = 32'h100; I_ARVALID = 1; I_ARADDR = 32'h200;
      #1 chk("t2 D_ARREADY", D_ARREADY, 1);
      chk("t2 I_ARREADY", I_ARREADY, 0);
      step();
      D_ARVALID = 0;
      #1 chk("t2 S_ARADDR D", S_ARADDR, 32'h100);
      chk("t2 OWNER D", OWNER, 1);
      serve(32'h1111_0000);
      #1 chk("t2 I_ARREADY later", I_ARREADY, 1);
      step();
      I_ARVALID = 0;
      #1 chk("t2 S_ARADDR I", S_ARADDR, 32'h200);
      serve(32'h2222_0000);

      // 3: D streak against a waiting I
      D_ARVALID = 1; D_ARADDR = 32'h300; I_ARVALID = 1; I_ARADDR = 32'h400;
      for (int k = 0; k < 6; k++) begin
         #1 grants[k] = D_ARREADY;
         chk("t3 one grant", 32'(D_ARREADY) + 32'(I_ARREADY), 1);
         step();
         serve(32'h3000_0000 + k);
      end
      chk("t3 grant order", grants, 6'b101111);
      D_ARVALID = 0; I_ARVALID = 0;

      // 4: slave and requester backpressure
      D_ARVALID = 1; D_ARADDR = 32'h500;
      step();
      D_ARVALID = 0;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) S_ARREADY = 1;
         #1 chk("t4 S_ARVALID held", S_ARVALID, 1);
         chk("t4 S_ARADDR held", S_ARADDR, 32'h500);
         step();
      end
      S_ARREADY = 0; S_RVALID = 1; S_RDATA = 32'hCAFE_F00D;
      for (int k = 0; k < 2; k++) begin
         #1 chk("t4 S_RREADY low", S_RREADY, 0);
         chk("t4 D_RVALID", D_RVALID, 1);
         step();
      end
      D_RREADY = 1;
      #1 chk("t4 S_RREADY high", S_RREADY, 1);
      step();
      S_RVALID = 0; D_RREADY = 0;
      #1 chk("t4 back idle S_RREADY", S_RREADY, 0);

      // 5: reset while a D read is in DATA
      D_ARVALID = 1; D_ARADDR = 32'h700; I_ARVALID = 1; I_ARADDR = 32'h600;
      step();
      D_ARVALID = 0; I_ARVALID = 0;
      S_ARREADY = 1;
      step();
      S_ARREADY = 0;
      rst_n = 0;
      step();
      rst_n = 1;
      #1 chk("t5 S_ARVALID", S_ARVALID, 0);
      chk("t5 S_ARADDR", S_ARADDR, 0);
      chk("t5 OWNER", OWNER, 0);
      chk("t5 S_RREADY", S_RREADY, 0);
      I_ARVALID = 1; I_ARADDR = 32'h600;
      #1 chk("t5 I_ARREADY", I_ARREADY, 1);
      step();
      I_ARVALID = 0;
      #1 chk("t5 S_ARADDR I", S_ARADDR, 32'h600);
      serve(32'h6666_6666);
      step(); step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
